// File: rtl/tt_uart_pkg.sv
// Shared frame constants and state encodings for the tt_uart console transceiver.
package tt_uart_pkg;

    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = DATA_BITS + 2;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ACK,
        TX_SHIFT
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/tt_uart_rx.sv
// 8N1 oversampling receiver with one-byte holding register and req/ack read port.
// Byte visible one cycle after the stop-bit centre; no backpressure, overrun keeps the newest byte.
module tt_uart_rx
    import tt_uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_clk,
    input  logic                 rx_in,
    input  logic                 rx_req,
    output logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_empty
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    logic [1:0]           sync;
    logic                 rx_s;
    rx_state_t            state, state_nxt;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 wait_high;
    logic                 mid_start, bit_centre;
    logic                 frame_ok, frame_err;

    assign rx_s       = sync[1];
    assign mid_start  = rx_clk && (tick == TW'(OVERSAMPLE / 2 - 1));
    assign bit_centre = rx_clk && (tick == TW'(OVERSAMPLE - 1));

    always_comb begin
        state_nxt = state;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        case (state)
            RX_IDLE:  if (rx_clk && !rx_s && !wait_high) state_nxt = RX_START;
            RX_START: if (mid_start) state_nxt = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_centre && (bit_idx == BW'(DATA_BITS - 1))) state_nxt = RX_STOP;
            RX_STOP: begin
                if (bit_centre) begin
                    state_nxt = RX_IDLE;
                    frame_ok  = rx_s;
                    frame_err = !rx_s;
                end
            end
            default:  state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync      <= 2'b11;
            state     <= RX_IDLE;
            tick      <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            wait_high <= 1'b0;
            rx_data   <= '0;
            rx_empty  <= 1'b1;
            rx_ack    <= 1'b0;
        end else begin
            sync  <= {sync[0], rx_in};
            state <= state_nxt;

            // Tick wraps at OVERSAMPLE, so each data bit centre follows the previous by one bit time.
            if (state != state_nxt) begin
                tick <= '0;
            end else if (rx_clk) begin
                tick <= tick + TW'(1);
            end

            if (state == RX_START) begin
                bit_idx <= '0;
            end else if (state == RX_DATA && bit_centre) begin
                shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                bit_idx <= bit_idx + BW'(1);
            end

            // After a framing error the line must return high before a new start is trusted.
            if (frame_err) begin
                wait_high <= 1'b1;
            end else if (rx_s) begin
                wait_high <= 1'b0;
            end

            if (frame_ok && !rx_ack) begin
                rx_data  <= shreg;
                rx_empty <= 1'b0;
            end

            if (!rx_ack && rx_req && !rx_empty) begin
                rx_ack <= 1'b1;
            end else if (rx_ack && !rx_req) begin
                rx_ack   <= 1'b0;
                rx_empty <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tt_uart.sv
// PDP-8 console UART: 8N1 transmitter inline, receiver in tt_uart_rx; strobe-paced bit timing.
// TX accepts one byte per frame (tx_ack next cycle); requests are held off while tx_empty=0.
module tt_uart
    import tt_uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_clk,
    input  logic                 tx_req,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ack,
    output logic                 tx_empty,
    input  logic                 rx_clk,
    input  logic                 rx_req,
    output logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_empty,
    input  logic                 rx_in,
    output logic                 tx_out
);

    localparam int CW = $clog2(FRAME_BITS + 1);

    tx_state_t             tx_state, tx_state_nxt;
    logic [FRAME_BITS-1:0] tx_frame;
    logic [CW-1:0]         tx_cnt;
    logic                  tx_busy;
    logic                  tx_accept, tx_done;

    assign tx_accept = (tx_state == TX_IDLE) && tx_req;
    assign tx_done   = tx_busy && tx_clk && (tx_cnt == CW'(FRAME_BITS));
    assign tx_ack    = (tx_state == TX_ACK);
    assign tx_empty  = !tx_busy;

    // ACK tracks the handshake, SHIFT covers a frame still in flight after the handshake closed.
    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE:  if (tx_req) tx_state_nxt = TX_ACK;
            TX_ACK:   if (!tx_req) tx_state_nxt = (tx_busy && !tx_done) ? TX_SHIFT : TX_IDLE;
            TX_SHIFT: if (tx_done || !tx_busy) tx_state_nxt = TX_IDLE;
            default:  tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_frame <= '0;
            tx_cnt   <= '0;
            tx_busy  <= 1'b0;
            tx_out   <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            if (tx_accept) begin
                tx_frame <= {STOP_BIT, tx_data, START_BIT};
                tx_cnt   <= '0;
                tx_busy  <= 1'b1;
            end else if (tx_busy && tx_clk) begin
                // The strobe after the stop bit only closes the frame; tx_out already sits high.
                if (tx_cnt == CW'(FRAME_BITS)) begin
                    tx_busy <= 1'b0;
                end else begin
                    tx_out   <= tx_frame[0];
                    tx_frame <= tx_frame >> 1;
                    tx_cnt   <= tx_cnt + CW'(1);
                end
            end
        end
    end

    tt_uart_rx #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .rx_clk  (rx_clk),
        .rx_in   (rx_in),
        .rx_req  (rx_req),
        .rx_ack  (rx_ack),
        .rx_data (rx_data),
        .rx_empty(rx_empty)
    );

endmodule

// File: tb/tb_tt_uart.sv
// Bench for tt_uart: strobe generators, a serial-line TX decoder and a byte-level RX model.
module tb_tt_uart;

    localparam int OS     = 16;
    localparam int TX_DIV = 10;
    localparam int RX_DIV = 3;

    logic       clk, reset;
    logic       tx_clk, tx_req, tx_ack, tx_empty, tx_out;
    logic       rx_clk, rx_req, rx_ack, rx_empty, rx_in;
    logic [7:0] tx_data, rx_data;

    int checks   = 0;
    int failures = 0;
    int tc       = 0;
    int rc       = 0;

    logic [8:0] tx_got[$];
    logic [7:0] m_data;
    logic       m_empty;
    logic       m_hs;

    tt_uart #(.OVERSAMPLE(OS)) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_clk  (tx_clk),
        .tx_req  (tx_req),
        .tx_data (tx_data),
        .tx_ack  (tx_ack),
        .tx_empty(tx_empty),
        .rx_clk  (rx_clk),
        .rx_req  (rx_req),
        .rx_ack  (rx_ack),
        .rx_data (rx_data),
        .rx_empty(rx_empty),
        .rx_in   (rx_in),
        .tx_out  (tx_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tx_clk = 1'b0;
        rx_clk = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tc = (tc + 1) % TX_DIV;
            rc = (rc + 1) % RX_DIV;
            tx_clk = (tc == 0);
            rx_clk = (rc == 0);
        end
    end

    // Decodes tx_out as a remote receiver would, one sample per tx_clk period.
    initial begin
        int         pos;
        logic [7:0] b;
        pos = -1;
        b   = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_clk === 1'b1) begin
                @(negedge clk);
                if (pos < 0) begin
                    if (tx_out === 1'b0) pos = 0;
                end else if (pos < 8) begin
                    b[pos] = tx_out;
                    pos++;
                end else begin
                    tx_got.push_back({tx_out, b});
                    pos = -1;
                end
            end
        end
    end

    task automatic wait_tx_frames(input int n, input string nm);
        int cyc = 0;
        while (tx_got.size() < n && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (tx_got.size() < n) begin
            failures++;
            $display("FAIL %s_frames: got %0d frames, required %0d", nm, tx_got.size(), n);
        end
    endtask

    task automatic pop_tx_frame(input logic [7:0] d, input string nm);
        logic [8:0] f;
        f = (tx_got.size() > 0) ? tx_got.pop_front() : 9'h000;
        checks++;
        if (f !== {1'b1, d}) begin
            failures++;
            $display("FAIL %s_line: stop+data=%h, required %h", nm, f, {1'b1, d});
        end
    endtask

    task automatic tx_handshake(input logic [7:0] d, input string nm);
        int cyc = 0;
        tx_data = d;
        tx_req  = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
        end while (tx_ack !== 1'b1 && cyc < 3000);
        checks++;
        if (tx_ack !== 1'b1 || tx_empty !== 1'b0) begin
            failures++;
            $display("FAIL %s_accept: tx_ack=%b tx_empty=%b, required 1 0", nm, tx_ack, tx_empty);
        end
        tx_req  = 1'b0;
        tx_data = 8'($urandom);
        @(negedge clk);
        checks++;
        if (tx_ack !== 1'b0) begin
            failures++;
            $display("FAIL %s_ack_drop: tx_ack=%b, required 0", nm, tx_ack);
        end
    endtask

    task automatic rx_strobes(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (rx_clk !== 1'b1) @(negedge clk);
        end
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        rx_strobes(1);
        for (int i = 0; i < 10; i++) begin
            rx_in = f[i];
            rx_strobes(OS);
        end
        rx_in = 1'b1;
        rx_strobes(4);
        if (stop && !m_hs) begin
            m_data  = d;
            m_empty = 1'b0;
        end
    endtask

    task automatic rx_read(input string nm);
        checks++;
        if (rx_empty !== m_empty || rx_data !== m_data) begin
            failures++;
            $display("FAIL %s_held: rx_empty=%b rx_data=%h, required %b %h", nm, rx_empty, rx_data, m_empty, m_data);
        end
        rx_req = 1'b1;
        @(negedge clk);
        checks++;
        if (rx_ack !== 1'b1 || rx_data !== m_data) begin
            failures++;
            $display("FAIL %s_ack: rx_ack=%b rx_data=%h, required 1 %h", nm, rx_ack, rx_data, m_data);
        end
        rx_req = 1'b0;
        @(negedge clk);
        m_empty = 1'b1;
        checks++;
        if (rx_ack !== 1'b0 || rx_empty !== 1'b1 || rx_data !== m_data) begin
            failures++;
            $display("FAIL %s_release: rx_ack=%b rx_empty=%b rx_data=%h, required 0 1 %h", nm, rx_ack, rx_empty, rx_data, m_data);
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        tx_req  = 1'b0;
        tx_data = 8'h00;
        rx_req  = 1'b0;
        rx_in   = 1'b1;
        m_data  = 8'h00;
        m_empty = 1'b1;
        m_hs    = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if ({tx_out, tx_empty, rx_empty, tx_ack, rx_ack} !== 5'b11100) begin
            failures++;
            $display("FAIL reset_flags: out/txe/rxe/txack/rxack=%b, required 11100", {tx_out, tx_empty, rx_empty, tx_ack, rx_ack});
        end
        checks++;
        if (rx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_rx_data: rx_data=%h, required 00", rx_data);
        end
        tx_got.delete();
    endtask

    task automatic test_tx_55();
        int cyc = 0;
        tx_data = 8'h55;
        tx_req  = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_ack !== 1'b1 || tx_empty !== 1'b0) begin
            failures++;
            $display("FAIL tx55_accept: tx_ack=%b tx_empty=%b, required 1 0", tx_ack, tx_empty);
        end
        tx_req = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_ack !== 1'b0) begin
            failures++;
            $display("FAIL tx55_ack_drop: tx_ack=%b, required 0", tx_ack);
        end
        wait_tx_frames(1, "tx55");
        while (tx_clk !== 1'b1 && cyc < 2 * TX_DIV) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (tx_empty !== 1'b0) begin
            failures++;
            $display("FAIL tx55_busy_in_stop: tx_empty=%b, required 0", tx_empty);
        end
        @(negedge clk);
        checks++;
        if (tx_empty !== 1'b1 || tx_out !== 1'b1) begin
            failures++;
            $display("FAIL tx55_done: tx_empty=%b tx_out=%b, required 1 1", tx_empty, tx_out);
        end
        pop_tx_frame(8'h55, "tx55");
    endtask

    task automatic test_tx_random();
        for (int i = 0; i < 3; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            repeat ($urandom_range(0, 15)) @(negedge clk);
            tx_handshake(d, "tx_rand");
            wait_tx_frames(1, "tx_rand");
            pop_tx_frame(d, "tx_rand");
            repeat (2 * TX_DIV) @(negedge clk);
        end
    endtask

    task automatic test_rx_a3();
        rx_frame(8'hA3, 1'b1);
        rx_read("rx_a3");
        rx_strobes(OS);
        checks++;
        if (rx_data !== 8'hA3 || rx_empty !== 1'b1) begin
            failures++;
            $display("FAIL rx_a3_stable: rx_data=%h rx_empty=%b, required a3 1", rx_data, rx_empty);
        end
    endtask

    task automatic test_rx_errors();
        rx_strobes(1);
        rx_in = 1'b0;
        rx_strobes(4);
        rx_in = 1'b1;
        rx_strobes(3 * OS);
        checks++;
        if (rx_empty !== 1'b1) begin
            failures++;
            $display("FAIL rx_glitch: rx_empty=%b, required 1", rx_empty);
        end
        rx_frame(8'($urandom), 1'b0);
        rx_strobes(OS);
        checks++;
        if (rx_empty !== 1'b1) begin
            failures++;
            $display("FAIL rx_framing: rx_empty=%b, required 1", rx_empty);
        end
        rx_frame(8'h41, 1'b1);
        rx_read("rx_41");
    endtask

    task automatic test_rx_overrun();
        rx_frame(8'h31, 1'b1);
        rx_frame(8'h32, 1'b1);
        checks++;
        if (rx_data !== 8'h32 || rx_empty !== 1'b0) begin
            failures++;
            $display("FAIL rx_overrun: rx_data=%h rx_empty=%b, required 32 0", rx_data, rx_empty);
        end
        rx_req = 1'b1;
        @(negedge clk);
        m_hs = 1'b1;
        checks++;
        if (rx_ack !== 1'b1) begin
            failures++;
            $display("FAIL rx_drop_ack: rx_ack=%b, required 1", rx_ack);
        end
        rx_frame(8'($urandom), 1'b1);
        checks++;
        if (rx_data !== m_data) begin
            failures++;
            $display("FAIL rx_drop_data: rx_data=%h, required %h", rx_data, m_data);
        end
        rx_req = 1'b0;
        @(negedge clk);
        m_hs    = 1'b0;
        m_empty = 1'b1;
        checks++;
        if (rx_ack !== 1'b0 || rx_empty !== 1'b1 || rx_data !== 8'h32) begin
            failures++;
            $display("FAIL rx_drop_release: rx_ack=%b rx_empty=%b rx_data=%h, required 0 1 32", rx_ack, rx_empty, rx_data);
        end
    endtask

    task automatic test_rx_random();
        for (int i = 0; i < 3; i++) begin
            rx_strobes($urandom_range(0, 20));
            rx_frame(8'($urandom), 1'b1);
            rx_read("rx_rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d1, d2;
        logic       early;
        int         cyc = 0;
        d1 = 8'($urandom);
        d2 = 8'($urandom);
        tx_handshake(d1, "b2b_first");
        tx_data = d2;
        tx_req  = 1'b1;
        early   = 1'b0;
        while (tx_empty === 1'b0 && cyc < 3000) begin
            if (tx_ack !== 1'b0) early = 1'b1;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (early || tx_ack !== 1'b0 || tx_empty !== 1'b1) begin
            failures++;
            $display("FAIL b2b_hold: early_ack=%b tx_ack=%b tx_empty=%b, required 0 0 1", early, tx_ack, tx_empty);
        end
        @(negedge clk);
        checks++;
        if (tx_ack !== 1'b1 || tx_empty !== 1'b0) begin
            failures++;
            $display("FAIL b2b_second_accept: tx_ack=%b tx_empty=%b, required 1 0", tx_ack, tx_empty);
        end
        tx_req = 1'b0;
        @(negedge clk);
        wait_tx_frames(2, "b2b");
        pop_tx_frame(d1, "b2b_first");
        pop_tx_frame(d2, "b2b_second");
    endtask

    task automatic test_full_duplex();
        fork
            tx_handshake(8'hFF, "fdx_tx");
            rx_frame(8'h00, 1'b1);
        join
        wait_tx_frames(1, "fdx_tx");
        pop_tx_frame(8'hFF, "fdx_tx");
        rx_read("fdx_rx");
    endtask

    initial begin
        test_reset();
        test_tx_55();
        test_tx_random();
        test_rx_a3();
        test_rx_errors();
        test_rx_overrun();
        test_rx_random();
        test_back_to_back();
        test_full_duplex();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
